// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and default baud divisor.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of each period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins so a new frame always starts a fresh bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = enable & ~clear & (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PAR_EVEN,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_data,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_par
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY_MODE != PAR_NONE);

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
        if (PARITY_MODE == PAR_ODD) begin
            return ~(^w);
        end else begin
            return ^w;
        end
    endfunction

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_data_q, tx_data_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 accept_s;
    logic                 bit_tick_s;

    assign accept_s = tx_valid & tx_ready_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_s),
        .enable  (state_q != ST_IDLE),
        .bit_tick(bit_tick_s)
    );

    // Next-state, shift register and line level; tx_data_d is the level for the coming bit period.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_data_d  = tx_data_q;
        tx_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_data_d = 1'b1;
                if (accept_s) begin
                    state_d    = ST_START;
                    shift_d    = tx_data_in;
                    parity_d   = calc_parity(tx_data_in);
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_data_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_d   = ST_DATA;
                    tx_data_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (HAS_PAR) begin
                            state_d   = ST_PARITY;
                            tx_data_d = parity_q;
                        end else begin
                            state_d    = ST_STOP;
                            tx_data_d  = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        tx_data_d = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_d    = ST_STOP;
                    tx_data_d  = 1'b1;
                    stop_cnt_d = 1'b0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                tx_data_d = 1'b1;
                if (bit_tick_s) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tx_data_d = 1'b1;
            end
        endcase
        tx_ready_d = (state_d == ST_IDLE);
        tx_busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame and drives the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_data_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four configurations checked clock by clock against hand-built frames.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] din  [4];
    logic       vld  [4];
    logic       line [4];
    logic       rdy  [4];
    logic       busy [4];
    logic       done [4];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // 0: even, 8 bits, 1 stop, 4 clk/bit
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .tx_data_in(din[0][7:0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_data(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    // 1: odd, 8 bits, 1 stop, 4 clk/bit
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .tx_data_in(din[1][7:0]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_data(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    // 2: no parity, 7 bits, 2 stop, 4 clk/bit
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_nopar (
        .clk(clk), .reset(reset), .tx_data_in(din[2][6:0]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_data(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    // 3: even, 9 bits, 1 stop, 2 clk/bit
    uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(1)) u_fast (
        .clk(clk), .reset(reset), .tx_data_in(din[3]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_data(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        cmp({tag, " line"},  16'(line[k]), 16'd1);
        cmp({tag, " ready"}, 16'(rdy[k]),  16'd1);
        cmp({tag, " busy"},  16'(busy[k]), 16'd0);
        cmp({tag, " done"},  16'(done[k]), 16'd0);
    endtask

    // Called at the negedge right after acceptance; returns at the negedge of the tx_done cycle.
    task automatic check_frame(input int k, input string tag, input logic [8:0] w, input int nbits,
                               input int cpb, input bit has_par, input logic par, input int nstop);
        logic [15:0] seq;
        int n;
        seq = '0;
        seq[0] = 1'b0;
        for (int i = 0; i < nbits; i++) seq[1 + i] = w[i];
        n = 1 + nbits;
        if (has_par) begin
            seq[n] = par;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            seq[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < cpb; c++) begin
                cmp($sformatf("%s bit%0d clk%0d line", tag, b, c), 16'(line[k]), 16'(seq[b]));
                cmp($sformatf("%s bit%0d clk%0d done", tag, b, c), 16'(done[k]), 16'd0);
                cmp($sformatf("%s bit%0d clk%0d busy", tag, b, c), 16'(busy[k]), 16'd1);
                cmp($sformatf("%s bit%0d clk%0d ready", tag, b, c), 16'(rdy[k]), 16'd0);
                @(negedge clk);
            end
        end
        cmp({tag, " end done"},  16'(done[k]), 16'd1);
        cmp({tag, " end line"},  16'(line[k]), 16'd1);
        cmp({tag, " end busy"},  16'(busy[k]), 16'd0);
        cmp({tag, " end ready"}, 16'(rdy[k]),  16'd1);
    endtask

    task automatic send(input int k, input logic [8:0] w);
        @(negedge clk);
        din[k] = w;
        vld[k] = 1'b1;
        @(negedge clk);
        vld[k] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din[k] = 9'h000;
            vld[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check_idle(k, $sformatf("reset%0d", k));

        // 0xA5 even: data 1,0,1,0,0,1,0,1, parity 0
        send(0, 9'h0A5);
        check_frame(0, "evenA5", 9'h0A5, 8, 4, 1'b1, 1'b0, 1);
        // odd parity: 0x01 -> 0, 0x00 -> 1
        send(1, 9'h001);
        check_frame(1, "odd01", 9'h001, 8, 4, 1'b1, 1'b0, 1);
        send(1, 9'h000);
        check_frame(1, "odd00", 9'h000, 8, 4, 1'b1, 1'b1, 1);
        // even parity: 0x01 -> 1
        send(0, 9'h001);
        check_frame(0, "even01", 9'h001, 8, 4, 1'b1, 1'b1, 1);
        // no parity, 7 bits, 2 stop: 0,1,0,1,0,1,0,1 then 8 clocks high
        send(2, 9'h055);
        check_frame(2, "nopar55", 9'h055, 7, 4, 1'b0, 1'b0, 2);
        // 9 bits at 2 clk/bit: 0x1FF has nine ones -> even parity 1
        send(3, 9'h1FF);
        check_frame(3, "fast1FF", 9'h1FF, 9, 2, 1'b1, 1'b1, 1);

        // back-to-back with tx_valid held high; data changes while busy
        @(negedge clk);
        din[0] = 9'h012;
        vld[0] = 1'b1;
        @(negedge clk);
        din[0] = 9'h034;
        check_frame(0, "b2b12", 9'h012, 8, 4, 1'b1, 1'b0, 1);
        @(negedge clk);
        vld[0] = 1'b0;
        din[0] = 9'h077;
        check_frame(0, "b2b34", 9'h034, 8, 4, 1'b1, 1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_idle(0, $sformatf("after b2b %0d", i));
        end

        // reset during data bit 3 of 0xFF
        send(0, 9'h0FF);
        repeat (17) @(negedge clk);
        cmp("preabort line", 16'(line[0]), 16'd1);
        cmp("preabort busy", 16'(busy[0]), 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle(0, "abort");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_idle(0, $sformatf("post abort %0d", i));
        end
        send(0, 9'h03C);
        check_frame(0, "after reset 3C", 9'h03C, 8, 4, 1'b1, 1'b0, 1);
        @(negedge clk);
        check_idle(0, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter that serialises one word per valid/ready handshake onto a single line.
- Configurable baud divisor, data width, parity mode and stop-bit count.
- Sits between a byte/word producer (switch/button front end, FIFO or CPU register) and the board TX pin.
- Improves on the single-cycle-per-bit transmitter in three ways: real baud timing, handshake flow control, and a completion pulse.

Parameters:
- CLKS_PER_BIT, 868, clocks per bit period (100 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 1, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- Any out-of-range value is an elaboration-time error.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data_in  in  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  block can accept a word (high only in IDLE).
- tx_data  out  1  serial line; idles high.
- tx_busy  out  1  frame in progress (not IDLE).
- tx_done  out  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset: synchronous, active-high. Affects the next rising edge only.
  - Reset values: tx_data=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State returns to IDLE; counters and shift register are cleared.
  - A reset asserted mid-frame aborts the frame. The line goes high on that edge and no tx_done is produced.
- Handshake: a word is accepted on a rising edge where tx_valid & tx_ready are both high.
  - tx_data_in is latched into the shift register.
  - The parity bit is computed from the latched word: even = XOR of all bits; odd = inverted XOR.
  - tx_valid while busy is ignored; the word is not latched.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when PARITY_MODE = 0.
- Bit timing:
  - Each state holds for exactly CLKS_PER_BIT clocks; STOP holds for STOP_BITS × CLKS_PER_BIT.
  - The baud counter is cleared on acceptance, so bit timing is phase-locked to the frame start.
  - The counter runs 0..CLKS_PER_BIT-1. Its width is clog2(CLKS_PER_BIT).
- Output timing: tx_data is registered.
  - Acceptance at edge N gives tx_data=0 (start bit) from edge N+1.
  - Data bits are sent LSB first. A bit index counter runs 0..DATA_BITS-1 and is compared against DATA_BITS-1.
  - The parity bit follows the data bits; the stop bits are 1.
- Frame length: CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS) clocks, where P=1 if parity is enabled.
- End of frame:
  - On the edge ending the last stop period, the FSM enters IDLE.
  - tx_done=1 for that one cycle; tx_ready rises and tx_busy falls in the same cycle.
- Back-to-back frames: if tx_valid is high in that IDLE cycle, the next word is accepted.
  - The inter-frame gap is therefore exactly one clock of idle-high beyond the stop bits.
- Input stability: tx_data_in may change freely after acceptance.

Decomposition:
- Package uart_pkg holds:
  - Parity mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - FSM state encoding as a 3-bit enum.
  - Default CLKS_PER_BIT constant.
- One sub-module: uart_baud_gen, parametrised on CLKS_PER_BIT.
  - Inputs: clear and enable.
  - Output: a bit_tick pulse on the last clock of each bit period.
  - Later reused by the planned RX block.
- The FSM, shift register and parity logic stay in uart_tx_frame.

Test Plan:
- Even parity, CLKS_PER_BIT=4, DATA_BITS=8, send 0xA5:
  - Line after acceptance: 0, then 1,0,1,0,0,1,0,1, parity 0, stop 1; each level held 4 clocks.
  - tx_done pulses 44 clocks after the start bit begins.
- Odd parity, same config, PARITY_MODE=2:
  - 0x01 gives parity bit 0; 0x00 gives parity bit 1.
  - Repeat with even parity: 0x01 gives parity bit 1.
- No parity, two stop bits: PARITY_MODE=0, STOP_BITS=2, DATA_BITS=7, send 0x55.
  - Line: 0,1,0,1,0,1,0,1, then 8 clocks high.
  - Frame length 40 clocks; no parity slot.
- Back-to-back: tx_valid held high with 0x12 then 0x34.
  - Second start bit begins exactly 1 clock after tx_done.
  - tx_valid pulses during busy cause no extra frames, and tx_data_in changes mid-frame do not alter the frame.
- Reset mid-frame: assert reset during data bit 3 of 0xFF.
  - Next edge gives tx_data=1, tx_busy=0, tx_ready=1, and tx_done never pulses.
  - A new word after reset is sent cleanly with correct timing.
- Divider edge case: CLKS_PER_BIT=2 with 9 data bits, send 0x1FF.
  - All 9 bits are sent and each bit lasts 2 clocks.
